// File: rtl/nes_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nes_bus_pkg
// Description : Shared types and constants for the NES CPU bus master.
//               - cycle_kind_e : kind of the bus cycle in flight (IDLE/RD/WR)
//               - phase_e      : M2 half-period (PH_LOW/PH_HIGH)
//               - CPU_ADDR_W   : width of the CPU address bus driven (A14..A0)
// Revision    : 1.0 - initial release
// ============================================================================
package nes_bus_pkg;

  localparam int CPU_ADDR_W = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } cycle_kind_e;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

endpackage
`default_nettype wire

// File: rtl/nes_m2_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : nes_m2_phase_gen
// Description : M2 timebase. A counter runs 0..HALF-1 inside each half-period
//               and the LOW/HIGH phase toggles on every wrap. The (phase,
//               count) pair names the clk slot currently presented on the bus.
//               All strobes describe the slot that begins at the NEXT clk
//               edge, so the top level can register its outputs from them.
// Ports       : clk, rst              - clock, async active-high reset
//               o_m2_next             - next slot is in the HIGH phase
//               o_is_last_high        - next slot is the last HIGH clk
//               o_is_hold_clk         - next slot is LOW clk 0 (cycle start)
//               o_is_apply_clk        - next slot is LOW clk 1
//               o_romsel_window       - next slot is HIGH clk >= ROMSEL_DLY
// Revision    : 1.0 - initial release
// ============================================================================
module nes_m2_phase_gen #(
  parameter int HALF       = 6,
  parameter int ROMSEL_DLY = 1
) (
  input  logic clk,
  input  logic rst,
  output logic o_m2_next,
  output logic o_is_last_high,
  output logic o_is_hold_clk,
  output logic o_is_apply_clk,
  output logic o_romsel_window
);
  import nes_bus_pkg::*;

  localparam int            CW     = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] c_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] c_DLY  = CW'(ROMSEL_DLY);
  localparam logic [CW-1:0] c_ONE  = CW'(1);

  phase_e        r_phase;
  phase_e        w_phase_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= PH_LOW;
      r_cnt   <= '0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_cnt_nxt   = r_cnt + c_ONE;
    w_phase_nxt = r_phase;
    if (r_cnt == c_LAST) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = (r_phase == PH_LOW) ? PH_HIGH : PH_LOW;
    end
  end

  // Output decode of the upcoming slot
  always_comb begin
    o_m2_next       = (w_phase_nxt == PH_HIGH);
    o_is_last_high  = (w_phase_nxt == PH_HIGH) && (w_cnt_nxt == c_LAST);
    o_is_hold_clk   = (w_phase_nxt == PH_LOW)  && (w_cnt_nxt == '0);
    o_is_apply_clk  = (w_phase_nxt == PH_LOW)  && (w_cnt_nxt == c_ONE);
    o_romsel_window = (w_phase_nxt == PH_HIGH) && (w_cnt_nxt >= c_DLY);
  end

endmodule
`default_nettype wire

// File: rtl/nes_cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : nes_cpu_bus_master
// Description : Initiator of the NES cartridge CPU bus. Turns single-beat host
//               read/write commands into M2 / /ROMSEL / R/W / address / data
//               bus cycles of 2*HALF clks each. All outputs are registered.
// Ports       : clk, rst                         - clock, async active-high rst
//               i_cmd_valid/o_cmd_ready          - host command handshake
//               i_cmd_write/i_cmd_addr/i_cmd_wdata - command fields
//               o_rsp_valid/o_rsp_rdata          - read response (1-clk pulse)
//               o_m2, o_romsel, o_cpu_rw         - bus control
//               o_cpu_addr                       - A14..A0
//               o_cpu_data_out/o_cpu_data_oe     - write data and its enable
//               i_cpu_data_in                    - bus data sampled on reads
// Revision    : 1.0 - initial release
// ============================================================================
module nes_cpu_bus_master #(
  parameter int HALF       = 6,
  parameter int ROMSEL_DLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_write,
  input  logic [15:0] i_cmd_addr,
  input  logic [7:0]  i_cmd_wdata,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_rdata,
  output logic        o_m2,
  output logic        o_romsel,
  output logic        o_cpu_rw,
  output logic [14:0] o_cpu_addr,
  output logic [7:0]  o_cpu_data_out,
  output logic        o_cpu_data_oe,
  input  logic [7:0]  i_cpu_data_in
);
  import nes_bus_pkg::*;

  logic        w_m2_next;
  logic        w_is_last_high;
  logic        w_is_hold_clk;
  logic        w_is_apply_clk;
  logic        w_romsel_window;
  logic        w_hs;

  cycle_kind_e r_kind;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;

  nes_m2_phase_gen #(
    .HALF       (HALF),
    .ROMSEL_DLY (ROMSEL_DLY)
  ) u_phase (
    .clk             (clk),
    .rst             (rst),
    .o_m2_next       (w_m2_next),
    .o_is_last_high  (w_is_last_high),
    .o_is_hold_clk   (w_is_hold_clk),
    .o_is_apply_clk  (w_is_apply_clk),
    .o_romsel_window (w_romsel_window)
  );

  // o_cmd_ready is high exactly while the current slot is the last HIGH clk,
  // which is also when w_is_hold_clk is set, so the cycle boundary edge both
  // completes the handshake and starts the new cycle.
  assign w_hs = i_cmd_valid & o_cmd_ready;

  // Command register: latched once per bus cycle at the cycle boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kind  <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_is_hold_clk) begin
      if (w_hs) begin
        r_kind  <= i_cmd_write ? WR : RD;
        r_addr  <= i_cmd_addr;
        r_wdata <= i_cmd_wdata;
      end else begin
        r_kind  <= IDLE;
      end
    end
  end

  // Bus outputs. Address, R/W and data change only at LOW clk 1, one clk after
  // /ROMSEL has risen at LOW clk 0, so mappers latching on that edge see
  // stable values on both sides of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_m2           <= 1'b0;
      o_romsel       <= 1'b1;
      o_cpu_rw       <= 1'b1;
      o_cpu_addr     <= '0;
      o_cpu_data_out <= '0;
      o_cpu_data_oe  <= 1'b0;
      o_cmd_ready    <= 1'b0;
    end else begin
      o_m2        <= w_m2_next;
      o_cmd_ready <= w_is_last_high;
      o_romsel    <= ~(w_romsel_window && (r_kind != IDLE) && r_addr[15]);
      if (w_is_apply_clk) begin
        if (r_kind != IDLE) begin
          o_cpu_addr <= r_addr[CPU_ADDR_W-1:0];
        end
        o_cpu_rw      <= (r_kind != WR);
        // oe from the previous WR has been held through LOW clk 0; it is
        // re-asserted here only if this cycle is a write as well.
        o_cpu_data_oe <= (r_kind == WR);
        if (r_kind == WR) begin
          o_cpu_data_out <= r_wdata;
        end
      end
    end
  end

  // Read capture: the edge leaving the last HIGH clk samples the bus, the
  // response is presented during LOW clk 0 of the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
    end else begin
      o_rsp_valid <= w_is_hold_clk && (r_kind == RD);
      if (w_is_hold_clk && (r_kind == RD)) begin
        o_rsp_rdata <= i_cpu_data_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nes_cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_nes_cpu_bus_master
// Description : Directed self-checking bench for nes_cpu_bus_master with
//               HALF=4, ROMSEL_DLY=1 (8-clk bus cycle). Includes a tiny mapper
//               model that latches write data on /ROMSEL rising edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_cpu_bus_master;

  localparam int HALF       = 4;
  localparam int ROMSEL_DLY = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2;
  logic        romsel;
  logic        cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic [7:0]  r_bus;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nes_cpu_bus_master #(
    .HALF       (HALF),
    .ROMSEL_DLY (ROMSEL_DLY)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_write    (cmd_write),
    .i_cmd_addr     (cmd_addr),
    .i_cmd_wdata    (cmd_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_rdata    (rsp_rdata),
    .o_m2           (m2),
    .o_romsel       (romsel),
    .o_cpu_rw       (cpu_rw),
    .o_cpu_addr     (cpu_addr),
    .o_cpu_data_out (cpu_data_out),
    .o_cpu_data_oe  (cpu_data_oe),
    .i_cpu_data_in  (r_bus)
  );

  // CNROM-like mapper model: bank register latched on /ROMSEL rise during writes
  logic [7:0] bank = 8'h00;
  always @(posedge romsel) if (!cpu_rw) bank <= cpu_data_out;

  // Per-slot capture buffers (sampled on falling clk edges)
  logic        a_m2  [0:31];
  logic        a_rs  [0:31];
  logic        a_rw  [0:31];
  logic        a_oe  [0:31];
  logic        a_rv  [0:31];
  logic        a_rdy [0:31];
  logic [14:0] a_addr[0:31];
  logic [7:0]  a_do  [0:31];
  logic [7:0]  a_rd  [0:31];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cap(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a_m2[base+k]   = m2;
      a_rs[base+k]   = romsel;
      a_rw[base+k]   = cpu_rw;
      a_oe[base+k]   = cpu_data_oe;
      a_rv[base+k]   = rsp_valid;
      a_rdy[base+k]  = cmd_ready;
      a_addr[base+k] = cpu_addr;
      a_do[base+k]   = cpu_data_out;
      a_rd[base+k]   = rsp_rdata;
    end
  endtask

  // Present a command, wait (bounded) for ready, pass the handshake edge.
  task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d, input bit keep);
    bit got;
    got       = 1'b0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 24 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
    end
    chk("handshake_ready", 16'(got), 16'd1);
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  function automatic int romsel_low(input int from, input int to);
    int n;
    n = 0;
    for (int k = from; k <= to; k++) if (!a_rs[k]) n++;
    return n;
  endfunction

  // Two idle bus cycles starting at LOW clk 1 right after reset release.
  task automatic check_idle(input string tag);
    cap(0, 16);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_m2"},  16'(a_m2[k]),  16'(((k + 1) % 8) >= 4));
      chk({tag, "_rdy"}, 16'(a_rdy[k]), 16'(((k + 1) % 8) == 7));
      chk({tag, "_rs"},  16'(a_rs[k]),  16'd1);
      chk({tag, "_rw"},  16'(a_rw[k]),  16'd1);
      chk({tag, "_rv"},  16'(a_rv[k]),  16'd0);
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0000;
    cmd_wdata = 8'h00;
    r_bus     = 8'h00;

    // ---- reset values ----
    repeat (2) @(negedge clk);
    chk("rst_m2",     16'(m2),           16'd0);
    chk("rst_romsel", 16'(romsel),       16'd1);
    chk("rst_rw",     16'(cpu_rw),       16'd1);
    chk("rst_addr",   16'(cpu_addr),     16'h0000);
    chk("rst_dout",   16'(cpu_data_out), 16'h00);
    chk("rst_oe",     16'(cpu_data_oe),  16'd0);
    chk("rst_ready",  16'(cmd_ready),    16'd0);
    chk("rst_rv",     16'(rsp_valid),    16'd0);
    chk("rst_rdata",  16'(rsp_rdata),    16'h00);
    rst = 1'b0;

    // ---- idle after reset ----
    check_idle("idle");

    // ---- WR $8000 = $03 ----
    send(1'b1, 16'h8000, 8'h03, 1'b0);
    cap(0, 10);
    chk("wr_rw_hold",   16'(a_rw[0]),   16'd1);
    chk("wr_addr",      16'(a_addr[1]), 16'h0000);
    chk("wr_rw",        16'(a_rw[1]),   16'd0);
    chk("wr_oe",        16'(a_oe[1]),   16'd1);
    chk("wr_dout",      16'(a_do[1]),   16'h03);
    chk("wr_m2_high",   16'(a_m2[4]),   16'd1);
    chk("wr_rs_h0",     16'(a_rs[4]),   16'd1);
    chk("wr_rs_h1",     16'(a_rs[5]),   16'd0);
    chk("wr_rs_h3",     16'(a_rs[7]),   16'd0);
    chk("wr_rs_len",    16'(romsel_low(0, 9)), 16'd3);
    chk("wr_rs_rise",   16'(a_rs[8]),   16'd1);
    chk("wr_oe_hold",   16'(a_oe[8]),   16'd1);
    chk("wr_dout_hold", 16'(a_do[8]),   16'h03);
    chk("wr_rw_hold2",  16'(a_rw[8]),   16'd0);
    chk("wr_oe_drop",   16'(a_oe[9]),   16'd0);
    chk("wr_rw_idle",   16'(a_rw[9]),   16'd1);
    chk("wr_bank",      16'(bank),      16'h03);

    // ---- RD $C123, bus drives $5A ----
    r_bus = 8'h5A;
    send(1'b0, 16'hC123, 8'h00, 1'b0);
    cap(0, 10);
    chk("rd_addr_hold", 16'(a_addr[0]), 16'h0000);
    chk("rd_addr",      16'(a_addr[1]), 16'h4123);
    chk("rd_rw",        16'(a_rw[1]),   16'd1);
    chk("rd_oe",        16'(a_oe[1]),   16'd0);
    chk("rd_rs_h1",     16'(a_rs[5]),   16'd0);
    chk("rd_rs_len",    16'(romsel_low(0, 9)), 16'd3);
    chk("rd_rv_early",  16'(a_rv[7]),   16'd0);
    chk("rd_rv",        16'(a_rv[8]),   16'd1);
    chk("rd_rdata",     16'(a_rd[8]),   16'h5A);
    chk("rd_rv_pulse",  16'(a_rv[9]),   16'd0);
    chk("rd_rdata_hld", 16'(a_rd[9]),   16'h5A);

    // ---- RD $0123 (no /ROMSEL), bus drives $A7 ----
    r_bus = 8'hA7;
    send(1'b0, 16'h0123, 8'h00, 1'b0);
    cap(0, 10);
    chk("rdlo_addr",    16'(a_addr[1]), 16'h0123);
    chk("rdlo_rs_len",  16'(romsel_low(0, 9)), 16'd0);
    chk("rdlo_rv",      16'(a_rv[8]),   16'd1);
    chk("rdlo_rdata",   16'(a_rd[8]),   16'hA7);

    // ---- back-to-back WR $8000=$01 then RD $8000, bus drives $3C ----
    r_bus = 8'h3C;
    send(1'b1, 16'h8000, 8'h01, 1'b1);
    cmd_write = 1'b0;
    cmd_addr  = 16'h8000;
    cap(0, 8);
    chk("b2b_ready",    16'(a_rdy[7]),  16'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cap(8, 10);
    chk("b2b_rs_wr",    16'(a_rs[5]),   16'd0);
    chk("b2b_rs_rise",  16'(a_rs[8]),   16'd1);
    chk("b2b_rw_hold",  16'(a_rw[8]),   16'd0);
    chk("b2b_oe_hold",  16'(a_oe[8]),   16'd1);
    chk("b2b_dout",     16'(a_do[8]),   16'h01);
    chk("b2b_rw_rd",    16'(a_rw[9]),   16'd1);
    chk("b2b_oe_drop",  16'(a_oe[9]),   16'd0);
    chk("b2b_addr",     16'(a_addr[9]), 16'h0000);
    chk("b2b_rs_h0",    16'(a_rs[12]),  16'd1);
    chk("b2b_rs_h1",    16'(a_rs[13]),  16'd0);
    chk("b2b_rs_len",   16'(romsel_low(0, 17)), 16'd6);
    chk("b2b_rv",       16'(a_rv[16]),  16'd1);
    chk("b2b_rdata",    16'(a_rd[16]),  16'h3C);
    chk("b2b_bank",     16'(bank),      16'h01);

    // ---- reset during HIGH of WR $8000=$02 ----
    send(1'b1, 16'h8000, 8'h02, 1'b0);
    repeat (6) @(negedge clk);
    chk("mid_rs_low",   16'(romsel),    16'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_romsel",   16'(romsel),      16'd1);
    chk("mid_rw",       16'(cpu_rw),      16'd1);
    chk("mid_oe",       16'(cpu_data_oe), 16'd0);
    chk("mid_m2",       16'(m2),          16'd0);
    chk("mid_addr",     16'(cpu_addr),    16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rv",     16'(rsp_valid),   16'd0);
    end
    rst = 1'b0;
    check_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
